// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for a 5-stage RV32I pipeline: load-use bubbles, EX redirect
// flushes, and a data-memory wait state with timeout and deferred redirect replay.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_pc_redirect,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_stall,
  output logic             id_ex_flush,
  output logic             ex_mem_stall,
  output logic             mem_wb_bubble,
  output logic             redirect_replay,
  output logic             mem_err,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    REPLAY   = 2'd2
  } state_e;

  localparam int TW = $clog2(MEM_TIMEOUT + 1);

  state_e           state_q, state_d;
  logic             pending_q, pending_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic load_use;
  logic mem_busy;
  logic mem_release;

  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_rd)));
  assign mem_busy    = mem_req && !mem_ready;
  assign mem_release = mem_ready || (tmo_q >= TW'(MEM_TIMEOUT));

  always_comb begin
    pc_stall        = 1'b0;
    if_id_stall     = 1'b0;
    if_id_flush     = 1'b0;
    id_ex_stall     = 1'b0;
    id_ex_flush     = 1'b0;
    ex_mem_stall    = 1'b0;
    mem_wb_bubble   = 1'b0;
    redirect_replay = 1'b0;
    state_d         = state_q;
    pending_d       = pending_q;
    tmo_d           = tmo_q;
    err_d           = err_q;

    case (state_q)
      RUN: begin
        if (mem_busy) begin
          pc_stall      = 1'b1;
          if_id_stall   = 1'b1;
          id_ex_stall   = 1'b1;
          ex_mem_stall  = 1'b1;
          mem_wb_bubble = 1'b1;
          pending_d     = ex_pc_redirect;
          tmo_d         = TW'(1);
          state_d       = MEM_WAIT;
        end else if (ex_pc_redirect) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (load_use) begin
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          id_ex_flush = 1'b1;
        end
      end
      MEM_WAIT: begin
        // A redirect arriving on the release cycle is not flushed now, so it joins the replay.
        if (mem_release) begin
          if (!mem_ready) err_d = 1'b1;
          state_d = (pending_q || ex_pc_redirect) ? REPLAY : RUN;
        end else begin
          pc_stall      = 1'b1;
          if_id_stall   = 1'b1;
          id_ex_stall   = 1'b1;
          ex_mem_stall  = 1'b1;
          mem_wb_bubble = 1'b1;
          pending_d     = pending_q || ex_pc_redirect;
          tmo_d         = tmo_q + TW'(1);
        end
      end
      REPLAY: begin
        redirect_replay = 1'b1;
        if_id_flush     = 1'b1;
        id_ex_flush     = 1'b1;
        pending_d       = 1'b0;
        state_d         = RUN;
      end
      default: state_d = RUN;
    endcase

    if (rst) begin
      pc_stall        = 1'b0;
      if_id_stall     = 1'b0;
      if_id_flush     = 1'b0;
      id_ex_stall     = 1'b0;
      id_ex_flush     = 1'b0;
      ex_mem_stall    = 1'b0;
      mem_wb_bubble   = 1'b0;
      redirect_replay = 1'b0;
    end

    stall_cnt_d = (pc_stall && !(&stall_cnt_q)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    flush_cnt_d = (if_id_flush && !(&flush_cnt_q)) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      pending_q   <= 1'b0;
      tmo_q       <= '0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      tmo_q       <= tmo_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign state     = state_q;
  assign mem_err   = err_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed hazard scenarios followed by
// randomized traffic compared against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int TMO  = 4;
  localparam int CW   = 6;
  localparam int CMAX = (1 << CW) - 1;

  // Expected control vector order: pc, if_id_stall, if_id_flush, id_ex_stall,
  // id_ex_flush, ex_mem_stall, mem_wb_bubble, redirect_replay.
  localparam logic [7:0] C_NONE   = 8'b0000_0000;
  localparam logic [7:0] C_FREEZE = 8'b1101_0110;
  localparam logic [7:0] C_FLUSH  = 8'b0010_1000;
  localparam logic [7:0] C_LDUSE  = 8'b1100_1000;
  localparam logic [7:0] C_REPLAY = 8'b0010_1001;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [4:0]    id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic          id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0;
  logic          ex_mem_read = 1'b0, ex_pc_redirect = 1'b0;
  logic          mem_req = 1'b0, mem_ready = 1'b0;
  logic          pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
  logic          ex_mem_stall, mem_wb_bubble, redirect_replay, mem_err;
  logic [1:0]    state;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int assertCount = 0;
  int failCount   = 0;

  // Behavioural model: mode 0=running, 1=waiting on memory, 2=replaying redirect.
  int mMode = 0;
  int mWaitCycles = 0;
  bit mPending = 0;
  bit mErr = 0;
  int mStallN = 0;
  int mFlushN = 0;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_pc_redirect(ex_pc_redirect),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush), .ex_mem_stall(ex_mem_stall),
    .mem_wb_bubble(mem_wb_bubble), .redirect_replay(redirect_replay),
    .mem_err(mem_err), .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int unsigned observed, input int unsigned expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic bit modelLoadUse();
    if (!ex_mem_read || ex_rd == 5'd0) return 1'b0;
    return (id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd);
  endfunction

  function automatic logic [7:0] modelCtrl();
    bit busy;
    busy = mem_req && !mem_ready;
    if (rst) return C_NONE;
    if (mMode == 0) begin
      if (busy) return C_FREEZE;
      if (ex_pc_redirect) return C_FLUSH;
      if (modelLoadUse()) return C_LDUSE;
      return C_NONE;
    end
    if (mMode == 1) return (mem_ready || mWaitCycles >= TMO) ? C_NONE : C_FREEZE;
    return C_REPLAY;
  endfunction

  function automatic int sat(input int n);
    return (n > CMAX) ? CMAX : n;
  endfunction

  task automatic modelReset();
    mMode = 0; mWaitCycles = 0; mPending = 0; mErr = 0; mStallN = 0; mFlushN = 0;
  endtask

  task automatic modelAdvance();
    logic [7:0] c;
    c = modelCtrl();
    if (c[7]) mStallN++;
    if (c[5]) mFlushN++;
    case (mMode)
      0: if (mem_req && !mem_ready) begin
           mMode = 1; mWaitCycles = 1; mPending = ex_pc_redirect;
         end
      1: if (mem_ready || mWaitCycles >= TMO) begin
           if (!mem_ready) mErr = 1;
           mMode = (mPending || ex_pc_redirect) ? 2 : 0;
           mPending = 0;
         end else begin
           mWaitCycles++;
           mPending = mPending || ex_pc_redirect;
         end
      default: begin mMode = 0; mPending = 0; end
    endcase
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, "_ctrl"}, {pc_stall, if_id_stall, if_id_flush, id_ex_stall,
                                 id_ex_flush, ex_mem_stall, mem_wb_bubble, redirect_replay},
                modelCtrl());
    checkOutput({tag, "_state"}, state, mMode);
    checkOutput({tag, "_mem_err"}, mem_err, mErr);
    checkOutput({tag, "_stall_cnt"}, stall_cnt, sat(mStallN));
    checkOutput({tag, "_flush_cnt"}, flush_cnt, sat(mFlushN));
  endtask

  // Drive one cycle of inputs just after a negedge, check mid-cycle, advance the model on posedge.
  task automatic applyStimulus(input string tag, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2, input logic [4:0] rd,
                               input logic mr, input logic redir, input logic req, input logic rdy);
    id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
    ex_rd = rd; ex_mem_read = mr; ex_pc_redirect = redir; mem_req = req; mem_ready = rdy;
    #1 checkAll(tag);
    @(posedge clk);
    modelAdvance();
    @(negedge clk);
  endtask

  task automatic applyIdle(input string tag);
    applyStimulus(tag, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic doReset(input string tag);
    mem_req = 1'b1; mem_ready = 1'b0; ex_pc_redirect = 1'b1;
    rst = 1'b1;
    modelReset();
    #1 checkAll(tag);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    doReset("reset");

    applyStimulus("t1_lduse", 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("t1_stall_cnt_one", stall_cnt, 1);
    applyIdle("t1_idle");

    applyStimulus("t2_x0", 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus("t2_rs2", 5'd1, 5'd7, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);

    doReset("t3_reset");
    applyStimulus("t3_redir_lduse", 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("t3_flush_cnt_one", flush_cnt, 1);
    checkOutput("t3_stall_cnt_zero", stall_cnt, 0);

    doReset("t4_reset");
    for (int i = 0; i < 3; i++) applyStimulus("t4_busy", 0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b0);
    applyStimulus("t4_ready", 0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b1);
    checkOutput("t4_state_run", state, 0);
    checkOutput("t4_stall_cnt_three", stall_cnt, 3);

    applyStimulus("t5_busy", 0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b0);
    applyStimulus("t5_redir", 0, 0, 0, 0, 0, 0, 1'b1, 1'b1, 1'b0);
    applyStimulus("t5_ready", 0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b1);
    checkOutput("t5_state_replay", state, 2);
    applyStimulus("t5_replay", 0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b0);
    checkOutput("t5_state_back", state, 0);

    doReset("t6_reset");
    for (int i = 0; i < 5; i++) applyStimulus("t6_timeout", 0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b0);
    checkOutput("t6_mem_err_set", mem_err, 1);
    applyStimulus("t6_rewait", 0, 0, 0, 0, 0, 0, 1'b1, 1'b1, 1'b0);
    doReset("t6_mid_reset");
    applyIdle("t6_no_replay");
    checkOutput("t6_mem_err_clear", mem_err, 0);

    for (int i = 0; i < 1200; i++) begin
      if (i < 300 && $urandom_range(0, 59) == 0) doReset("rnd_reset");
      applyStimulus("rnd",
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 2) == 0),
                    1'($urandom_range(0, 3) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
